// File: rtl/gray_counter.sv
// gray_counter
//   Synchronous Gray-code up/down counter with a Gray-coded parallel load.
//   The binary count is the only true state. The Gray output is stored in its
//   own register, but it is computed from the same next value in the same
//   edge, so grayOut and binOut always describe the same count.
//
// Parameters
//   WIDTH  counter width in bits (must be 2 or more)
//   WRAP   1 = wrap modulo 2^WIDTH at the limits, 0 = saturate at the limits
//
// Ports
//   clk       rising-edge clock; all state updates happen here
//   reset     synchronous, active-high; clears every output
//   en        count enable; one step per enabled cycle
//   up        direction (1 = increment, 0 = decrement); used only when en = 1
//   load      load request; takes priority over counting
//   loadGray  Gray-coded load value, sampled when load = 1
//   grayOut   registered Gray code of the count
//   binOut    registered binary count
//   tc        registered terminal-count pulse (a step pushed past a limit)

module gray_counter #(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] loadGray,
  output logic [WIDTH-1:0] grayOut,
  output logic [WIDTH-1:0] binOut,
  output logic             tc
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_MIN = '0;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             tc_q, tc_d;

  logic [WIDTH-1:0] load_bin;
  logic             at_max;
  logic             at_min;

  // Gray to binary: each binary bit is the XOR of its own Gray bit and every
  // Gray bit above it. Writing it as a reduction over a shifted copy keeps the
  // logic free of a bit-to-bit dependency chain inside a single vector.
  always_comb begin
    load_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      load_bin[i] = ^(loadGray >> i);
    end
  end

  assign at_max = (cnt_q == CNT_MAX);
  assign at_min = (cnt_q == CNT_MIN);

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;

    if (load) begin
      cnt_d = load_bin;
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          tc_d  = 1'b1;
          cnt_d = WRAP ? CNT_MIN : CNT_MAX;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else begin
        if (at_min) begin
          tc_d  = 1'b1;
          cnt_d = WRAP ? CNT_MAX : CNT_MIN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
    end

    // Derived from cnt_d, not cnt_q, so both registers capture the same count.
    gray_d = cnt_d ^ (cnt_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      gray_q <= '0;
      tc_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      gray_q <= gray_d;
      tc_q   <= tc_d;
    end
  end

  assign grayOut = gray_q;
  assign binOut  = cnt_q;
  assign tc      = tc_q;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter. It runs three instances side by side
// (4-bit wrap, 4-bit saturate, 8-bit wrap) from shared controls. An integer
// reference model predicts the state of every instance.
`timescale 1ns/1ps

module tb_gray_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_gray = 8'h00;

  logic [3:0] gray_w4, bin_w4, gray_s4, bin_s4;
  logic [7:0] gray_w8, bin_w8;
  logic       tc_w4, tc_s4, tc_w8;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(4), .WRAP(1'b1)) u_w4 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .loadGray(load_gray[3:0]), .grayOut(gray_w4), .binOut(bin_w4), .tc(tc_w4));

  gray_counter #(.WIDTH(4), .WRAP(1'b0)) u_s4 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .loadGray(load_gray[3:0]), .grayOut(gray_s4), .binOut(bin_s4), .tc(tc_s4));

  gray_counter #(.WIDTH(8), .WRAP(1'b1)) u_w8 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .loadGray(load_gray), .grayOut(gray_w8), .binOut(bin_w8), .tc(tc_w8));

  // Observed outputs gathered by instance index: 0 = w4, 1 = s4, 2 = w8.
  logic [7:0] act_gray [3];
  logic [7:0] act_bin  [3];
  logic       act_tc   [3];
  assign act_gray[0] = {4'h0, gray_w4};
  assign act_gray[1] = {4'h0, gray_s4};
  assign act_gray[2] = gray_w8;
  assign act_bin[0]  = {4'h0, bin_w4};
  assign act_bin[1]  = {4'h0, bin_s4};
  assign act_bin[2]  = bin_w8;
  assign act_tc[0]   = tc_w4;
  assign act_tc[1]   = tc_s4;
  assign act_tc[2]   = tc_w8;

  // Reference model state.
  int  m_width [3] = '{4, 4, 8};
  bit  m_wrap  [3] = '{1'b1, 1'b0, 1'b1};
  int  m_cnt   [3] = '{0, 0, 0};
  int  m_tc    [3] = '{0, 0, 0};
  int  exp_gray[3] = '{0, 0, 0};

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] up_seq [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                              4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

  // Binary value of a Gray code: bit i is the parity of all Gray bits >= i.
  function automatic int gray_to_int(input int g, input int w);
    int b = 0;
    for (int i = 0; i < w; i++) begin
      if (($countones(g >> i) % 2) == 1) b = b | (1 << i);
    end
    return b;
  endfunction

  // Apply one edge of stimulus, advance the model, and return at the next
  // falling edge so that the outputs are read well away from the active edge.
  task automatic drive(input bit r, input bit l, input bit e, input bit u,
                       input logic [7:0] lg);
    int mx;
    reset = r; load = l; en = e; up = u; load_gray = lg;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      mx = (1 << m_width[k]) - 1;
      if (r) begin
        m_cnt[k] = 0; m_tc[k] = 0;
      end else if (l) begin
        m_cnt[k] = gray_to_int(int'(lg) & mx, m_width[k]); m_tc[k] = 0;
      end else if (e && u) begin
        if (m_cnt[k] == mx) begin
          m_tc[k] = 1; m_cnt[k] = m_wrap[k] ? 0 : mx;
        end else begin
          m_tc[k] = 0; m_cnt[k] = m_cnt[k] + 1;
        end
      end else if (e) begin
        if (m_cnt[k] == 0) begin
          m_tc[k] = 1; m_cnt[k] = m_wrap[k] ? mx : 0;
        end else begin
          m_tc[k] = 0; m_cnt[k] = m_cnt[k] - 1;
        end
      end else begin
        m_tc[k] = 0;
      end
      exp_gray[k] = m_cnt[k] ^ (m_cnt[k] >> 1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h5A);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (act_gray[k] !== 8'h00 || act_bin[k] !== 8'h00 || act_tc[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset dut%0d: gray=%h bin=%h tc=%b, expected 00/00/0",
                 k, act_gray[k], act_bin[k], act_tc[k]);
      end
    end
  endtask

  task automatic test_count_up();
    logic [7:0] prev_w4, prev_w8;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 16; i++) begin
      prev_w4 = act_gray[0];
      prev_w8 = act_gray[2];
      drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
      n_tests++;
      if (gray_w4 !== up_seq[i] || tc_w4 !== (i == 15)) begin
        n_fail++;
        $display("FAIL count_up step %0d: gray=%b tc=%b, expected %b tc=%b",
                 i, gray_w4, tc_w4, up_seq[i], (i == 15));
      end
      n_tests++;
      if ($countones(prev_w4 ^ act_gray[0]) != 1 || $countones(prev_w8 ^ act_gray[2]) != 1) begin
        n_fail++;
        $display("FAIL count_up one_bit step %0d: w4 %h->%h w8 %h->%h, expected one bit each",
                 i, prev_w4, act_gray[0], prev_w8, act_gray[2]);
      end
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (act_bin[k] !== 8'(m_cnt[k]) || act_gray[k] !== 8'(exp_gray[k]) ||
            act_tc[k] !== m_tc[k][0]) begin
          n_fail++;
          $display("FAIL count_up model dut%0d step %0d: bin=%h gray=%h tc=%b, expected %h/%h/%0d",
                   k, i, act_bin[k], act_gray[k], act_tc[k], m_cnt[k], exp_gray[k], m_tc[k]);
        end
      end
    end
  endtask

  task automatic test_load();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h0B);
    n_tests++;
    if (bin_w4 !== 4'b1101 || gray_w4 !== 4'b1011 || tc_w4 !== 1'b0) begin
      n_fail++;
      $display("FAIL load_beats_count: bin=%b gray=%b tc=%b, expected 1101/1011/0",
               bin_w4, gray_w4, tc_w4);
    end
    n_tests++;
    if (bin_w8 !== 8'h0D || gray_w8 !== 8'h0B) begin
      n_fail++;
      $display("FAIL load_w8: bin=%h gray=%h, expected 0d/0b", bin_w8, gray_w8);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    n_tests++;
    if (bin_w4 !== 4'b1100 || gray_w4 !== 4'b1010 || tc_w4 !== 1'b0) begin
      n_fail++;
      $display("FAIL load_then_down: bin=%b gray=%b tc=%b, expected 1100/1010/0",
               bin_w4, gray_w4, tc_w4);
    end
  endtask

  task automatic test_down_limit();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      if (i == 0) begin
        n_tests++;
        if (bin_w4 !== 4'b1111 || gray_w4 !== 4'b1000 || tc_w4 !== 1'b1) begin
          n_fail++;
          $display("FAIL down_wrap: bin=%b gray=%b tc=%b, expected 1111/1000/1",
                   bin_w4, gray_w4, tc_w4);
        end
      end
      n_tests++;
      if (bin_s4 !== 4'b0000 || gray_s4 !== 4'b0000 || tc_s4 !== 1'b1) begin
        n_fail++;
        $display("FAIL down_saturate edge %0d: bin=%b gray=%b tc=%b, expected 0000/0000/1",
                 i, bin_s4, gray_s4, tc_s4);
      end
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (act_bin[k] !== 8'(m_cnt[k]) || act_gray[k] !== 8'(exp_gray[k]) ||
            act_tc[k] !== m_tc[k][0]) begin
          n_fail++;
          $display("FAIL down_limit model dut%0d edge %0d: bin=%h gray=%h tc=%b, expected %h/%h/%0d",
                   k, i, act_bin[k], act_gray[k], act_tc[k], m_cnt[k], exp_gray[k], m_tc[k]);
        end
      end
    end
  endtask

  task automatic test_hold_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, $urandom_range(0, 1), 8'($urandom));
      n_tests++;
      if (bin_w4 !== 4'b0110 || gray_w4 !== 4'b0101 || tc_w4 !== 1'b0 ||
          bin_s4 !== 4'b0110 || bin_w8 !== 8'h06) begin
        n_fail++;
        $display("FAIL hold edge %0d: w4 bin=%b gray=%b tc=%b s4 bin=%b w8 bin=%h, expected 0110/0101/0 0110 06",
                 i, bin_w4, gray_w4, tc_w4, bin_s4, bin_w8);
      end
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (act_gray[k] !== 8'h00 || act_bin[k] !== 8'h00 || act_tc[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_run dut%0d: gray=%h bin=%h tc=%b, expected 00/00/0",
                 k, act_gray[k], act_bin[k], act_tc[k]);
      end
    end
  endtask

  task automatic test_wide_wrap();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h80);
    n_tests++;
    if (bin_w8 !== 8'hFF || gray_w8 !== 8'h80 || tc_w8 !== 1'b0) begin
      n_fail++;
      $display("FAIL wide_load: bin=%h gray=%h tc=%b, expected ff/80/0", bin_w8, gray_w8, tc_w8);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    n_tests++;
    if (bin_w8 !== 8'h00 || gray_w8 !== 8'h00 || tc_w8 !== 1'b1) begin
      n_fail++;
      $display("FAIL wide_wrap: bin=%h gray=%h tc=%b, expected 00/00/1", bin_w8, gray_w8, tc_w8);
    end
  endtask

  task automatic test_random();
    bit r, l, e, u;
    logic [7:0] lg;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 39) == 0);
      l  = ($urandom_range(0, 7) == 0);
      e  = ($urandom_range(0, 3) != 0);
      u  = $urandom_range(0, 1);
      lg = 8'($urandom);
      // Loads near the limits make saturation and wrap steps frequent.
      if ($urandom_range(0, 1) == 1) lg = $urandom_range(0, 1) ? 8'h80 : 8'h00;
      drive(r, l, e, u, lg);
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (act_bin[k] !== 8'(m_cnt[k]) || act_gray[k] !== 8'(exp_gray[k]) ||
            act_tc[k] !== m_tc[k][0]) begin
          n_fail++;
          $display("FAIL random dut%0d cycle %0d: bin=%h gray=%h tc=%b, expected %h/%h/%0d",
                   k, i, act_bin[k], act_gray[k], act_tc[k], m_cnt[k], exp_gray[k], m_tc[k]);
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_count_up();
    test_load();
    test_down_limit();
    test_hold_reset();
    test_wide_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
Parametrised synchronous Gray-code up/down counter. It also accepts a Gray-coded load value and converts it internally to binary. Every output is registered: the Gray count, its binary equivalent, and a terminal-count pulse. It is the sequential successor to the combinational 4-bit Gray-to-binary converter. Typical uses are position encoders, multi-bit pointer handoff, and any place needing a single-bit-change count sequence.

Parameters:
WIDTH, 4, counter width in bits; legal range >= 2.
WRAP, 1, 1 = modulo-2^WIDTH wrap at the limits; 0 = saturate at the limits.

Ports:
clk  input  1  single clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
en  input  1  count enable, one step per cycle while high
up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en = 1
load  input  1  load request
loadGray  input  WIDTH  Gray-coded load value, sampled when load = 1
grayOut  output  WIDTH  registered Gray code of the current count
binOut  output  WIDTH  registered binary value of the current count
tc  output  1  registered one-cycle terminal-count pulse

Behaviour:
- One clock. Reset is synchronous and active-high. No asynchronous paths.
- Reset values: grayOut = 0, binOut = 0, tc = 0.
- Internal state is the binary count cnt. binOut = cnt.
- grayOut is registered in the same edge as cnt, with grayOut = next_cnt ^ (next_cnt >> 1). The two outputs are never inconsistent.
- Priority at each rising edge: reset > load > en > hold.
- Load:
  - next_cnt = gray2bin(loadGray), where bin[WIDTH-1] = g[WIDTH-1] and bin[i] = bin[i+1] ^ g[i].
  - tc = 0. en and up are ignored that cycle.
- Count (en = 1, load = 0):
  - up = 1: next_cnt = cnt + 1.
  - up = 0: next_cnt = cnt - 1.
- Limits:
  - The up limit is cnt = 2^WIDTH - 1. The down limit is cnt = 0.
  - WRAP = 1, stepping past a limit: wraps modulo 2^WIDTH (all-ones -> 0 going up, 0 -> all-ones going down) and tc = 1 for that edge only.
  - WRAP = 0, stepping past a limit: cnt holds at the limit and tc = 1. tc stays 1 on every enabled cycle that pushes against the limit.
- Non-limit steps: tc = 0.
- Hold (en = 0, load = 0): cnt and grayOut unchanged, tc = 0.
- Latency: 1 cycle from sampled inputs to all outputs. No combinational input-to-output path.
- Gray property: every enabled non-saturated step changes exactly one bit of grayOut, including the wrap steps.
- Direction change mid-stream takes effect on the next enabled edge with no bubble.
- Reset mid-operation (any en, load, up): outputs go to reset values at that edge. Counting resumes from 0 on the following enabled edge.
- Width rule: all arithmetic is WIDTH bits. Overflow carry is discarded and is visible only through tc.

Test Plan:
- WIDTH=4, WRAP=1, assert reset for 1 edge with en=1, load=1 -> grayOut=0000, binOut=0000, tc=0 after that edge.
- WIDTH=4, WRAP=1, en=1, up=1 for 16 edges from 0:
  - grayOut steps 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000.
  - tc=1 only on the final edge.
  - Checker confirms exactly one bit changes per step.
- load=1, loadGray=1011, en=1, up=1 on the same edge -> binOut=1101, grayOut=1011, tc=0 (load beats count).
  - Next edge with en=1, up=0 -> binOut=1100, grayOut=1010.
- WIDTH=4, WRAP=1 from 0, en=1, up=0 -> binOut=1111, grayOut=1000, tc=1.
  - Repeat with WRAP=0 -> binOut=0000 held, tc=1 on each of 3 consecutive enabled edges.
- WIDTH=4, count to binOut=0110, then en=0 for 3 edges -> outputs frozen, tc=0.
  - Then reset on the next edge with en=1 -> all outputs 0.
- WIDTH=8, WRAP=1, load grayOut value of 0xFF (loadGray=10000000), then en=1, up=1 -> binOut=0x00, grayOut=0x00, tc=1.
